// File: rtl/mod_counter.sv
// Modulo-N up/down counter with an enable prescaler, saturating parallel load,
// a one-cycle wrap pulse and a sticky overflow flag.
module mod_counter #(
  parameter int              WIDTH    = 4,
  parameter longint unsigned MODULUS  = 16,
  parameter int              PRESCALE = 1
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             enable,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] Q,
  output logic             wrap,
  output logic             ovf
);

  // Divider needs at least one bit even when PRESCALE is 1 (it then stays at 0).
  localparam int DIV_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PRESCALE - 1);
  localparam logic [WIDTH-1:0] MAX_V    = WIDTH'(MODULUS - 64'd1);

  logic [WIDTH-1:0] q_q,    q_d;
  logic [DIV_W-1:0] div_q,  div_d;
  logic             wrap_q, wrap_d;
  logic             ovf_q,  ovf_d;
  logic [WIDTH-1:0] load_sat;

  // Out-of-range load values clamp to the top of the count range.
  always_comb begin
    load_sat = load_val;
    if (64'(load_val) >= MODULUS) begin
      load_sat = MAX_V;
    end
  end

  // Next-state: load beats enable; a step happens when the divider is on its last phase.
  always_comb begin
    q_d    = q_q;
    div_d  = div_q;
    wrap_d = 1'b0;
    if (load) begin
      q_d   = load_sat;
      div_d = '0;
    end else if (enable) begin
      if (div_q == DIV_LAST) begin
        div_d = '0;
        if (up) begin
          if (q_q == MAX_V) begin
            q_d    = '0;
            wrap_d = 1'b1;
          end else begin
            q_d = q_q + WIDTH'(1);
          end
        end else begin
          if (q_q == '0) begin
            q_d    = MAX_V;
            wrap_d = 1'b1;
          end else begin
            q_d = q_q - WIDTH'(1);
          end
        end
      end else begin
        div_d = div_q + DIV_W'(1);
      end
    end
    // Set wins over clear when both land on the same edge.
    ovf_d = (ovf_q & ~ovf_clr) | wrap_d;
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      q_q    <= '0;
      div_q  <= '0;
      wrap_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      q_q    <= q_d;
      div_q  <= div_d;
      wrap_q <= wrap_d;
      ovf_q  <= ovf_d;
    end
  end

  assign Q    = q_q;
  assign wrap = wrap_q;
  assign ovf  = ovf_q;

endmodule
